// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   requesters, A (ALU result) and B (memory load). When both are valid,
//   they are granted in round-robin order. Accepted writes appear on the
//   register-file write port one cycle later.
//   A per-register busy scoreboard lets the issue stage stall reads of
//   registers that still have writes pending.
//
// Ports
//   clk, reset                    clock; asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data/a_byte   requester A handshake + payload
//   b_valid/b_ready/b_reg/b_data/b_byte   requester B handshake + payload
//   claim_valid, claim_reg        issue stage reserves a destination register
//   chk_reg1, chk_reg2, stall     source hazard check (combinational)
//   write_reg, write_data, byteOperations, regWrite   register-file write port
//   busy_count                    number of busy registers (registered)
//   claim_err                     sticky flag: a claim hit an already-busy register
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_byte,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_byte,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              stall,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              byteOperations,
  output logic              regWrite,
  output logic [ADDR_W:0]   busy_count,
  output logic              claim_err
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [ADDR_W:0]     busy_count_q, busy_count_d;
  logic                claim_err_q, claim_err_d;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic                byte_op_q;
  logic                reg_write_q;

  logic                grant_a, grant_b, xfer;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_byte;
  logic [NREG-1:0]     retire_mask, claim_mask;

  // Round robin: on contention, grant the requester that did not win last.
  assign grant_a = a_valid & (~b_valid | (last_grant_q == GRANT_B));
  assign grant_b = b_valid & (~a_valid | (last_grant_q == GRANT_A));
  assign xfer    = grant_a | grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_reg      = b_reg;
    sel_data     = b_data;
    sel_byte     = b_byte;
    last_grant_d = last_grant_q;
    if (grant_a) begin
      sel_reg  = a_reg;
      sel_data = a_data;
      sel_byte = a_byte;
    end
    if (grant_a) last_grant_d = GRANT_A;
    else if (grant_b) last_grant_d = GRANT_B;
    // A byte write keeps only the low byte, zero-extended.
    if (sel_byte) sel_data = {{(DATA_W-BYTE_W){1'b0}}, sel_data[BYTE_W-1:0]};
  end

  // Scoreboard next state. Register 0 never enters the masks. Because claims
  // are OR-ed in after retires are cleared, a claim wins when both hit the
  // same register on the same edge.
  always_comb begin
    retire_mask = '0;
    claim_mask  = '0;
    if (xfer && sel_reg != '0) retire_mask[sel_reg] = 1'b1;
    if (claim_valid && claim_reg != '0) claim_mask[claim_reg] = 1'b1;
    busy_d = (busy_q & ~retire_mask) | claim_mask;

    // A same-edge retire frees the slot that the claim takes, so it is not an error.
    claim_err_d = claim_err_q |
                  (claim_valid && claim_reg != '0 && busy_q[claim_reg] &&
                   !retire_mask[claim_reg]);

    busy_count_d = '0;
    for (int i = 0; i < NREG; i++)
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the scoreboard is a flop vector that reset must clear, not a RAM,
  // so clearing it on reset is intended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      busy_q       <= '0;
      busy_count_q <= '0;
      claim_err_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      byte_op_q    <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      claim_err_q  <= claim_err_d;
      reg_write_q  <= xfer && (sel_reg != '0);
      if (xfer) begin
        write_reg_q  <= sel_reg;
        write_data_q <= sel_data;
        byte_op_q    <= sel_byte;
      end
    end
  end

  assign stall          = busy_q[chk_reg1] | busy_q[chk_reg2];
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;
  assign byteOperations = byte_op_q;
  assign regWrite       = reg_write_q;
  assign busy_count     = busy_count_q;
  assign claim_err      = claim_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change on the falling
// edge. Outputs are sampled 1 ns after an input change or a rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_byte = 1'b0, b_byte = 1'b0;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_reg = '0, chk_reg1 = '0, chk_reg2 = '0;
  logic        stall;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        byteOperations, regWrite;
  logic [5:0]  busy_count;
  logic        claim_err;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .BYTE_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data), .a_byte(a_byte),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data), .b_byte(b_byte),
    .claim_valid(claim_valid), .claim_reg(claim_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .stall(stall),
    .write_reg(write_reg), .write_data(write_data),
    .byteOperations(byteOperations), .regWrite(regWrite),
    .busy_count(busy_count), .claim_err(claim_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL reset_regWrite got=%0h exp=0", regWrite); end
    checks++; if (write_reg !== 5'd0) begin failures++; $display("FAIL reset_write_reg got=%0h exp=0", write_reg); end
    checks++; if (write_data !== 32'd0) begin failures++; $display("FAIL reset_write_data got=%0h exp=0", write_data); end
    checks++; if (byteOperations !== 1'b0) begin failures++; $display("FAIL reset_byteOps got=%0h exp=0", byteOperations); end
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
    checks++; if (claim_err !== 1'b0) begin failures++; $display("FAIL reset_claim_err got=%0h exp=0", claim_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    do_reset();
  endtask

  task automatic test_single_a();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'hFF; a_byte = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%0b%0b exp=10", a_ready, b_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (regWrite !== 1'b1) begin failures++; $display("FAIL single_regWrite got=%0h exp=1", regWrite); end
    checks++; if (write_reg !== 5'd2) begin failures++; $display("FAIL single_write_reg got=%0d exp=2", write_reg); end
    checks++; if (write_data !== 32'h000000FF) begin failures++; $display("FAIL single_write_data got=%0h exp=ff", write_data); end
    checks++; if (byteOperations !== 1'b0) begin failures++; $display("FAIL single_byteOps got=%0h exp=0", byteOperations); end
    @(posedge clk); #1;
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL single_idle_regWrite got=%0h exp=0", regWrite); end
    checks++; if (write_reg !== 5'd2) begin failures++; $display("FAIL single_hold_write_reg got=%0d exp=2", write_reg); end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hAAAA_0003; a_byte = 1'b0;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'hBBBB_0004; b_byte = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        failures++; $display("FAIL rr_grant_%0d got=%0b%0b exp_a=%0b", i, a_ready, b_ready, (i % 2 == 0));
      end
      @(posedge clk); #1;
      checks++;
      if (regWrite !== 1'b1 || write_reg !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
        failures++; $display("FAIL rr_write_%0d got_we=%0b reg=%0d exp_reg=%0d", i, regWrite, write_reg, (i % 2 == 0) ? 3 : 4);
      end
    end
    checks++; if (write_data !== 32'hBBBB_0004) begin failures++; $display("FAIL rr_last_data got=%0h exp=bbbb0004", write_data); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL rr_idle_regWrite got=%0h exp=0", regWrite); end
  endtask

  task automatic test_byte_b();
    @(negedge clk);
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h1234ABCD; b_byte = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL byte_ready got=%0b%0b exp=01", a_ready, b_ready); end
    @(posedge clk); #1;
    b_valid = 1'b0; b_byte = 1'b0;
    checks++; if (write_data !== 32'h000000CD) begin failures++; $display("FAIL byte_write_data got=%0h exp=cd", write_data); end
    checks++; if (byteOperations !== 1'b1) begin failures++; $display("FAIL byte_byteOps got=%0h exp=1", byteOperations); end
    checks++; if (write_reg !== 5'd7 || regWrite !== 1'b1) begin failures++; $display("FAIL byte_write_reg got=%0d we=%0b exp=7/1", write_reg, regWrite); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 5'd5;
    @(posedge clk); #1;
    claim_valid = 1'b0; chk_reg1 = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_chk1 got=%0h exp=1", stall); end
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL sb_busy_count got=%0d exp=1", busy_count); end
    chk_reg1 = 5'd0; chk_reg2 = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_chk2 got=%0h exp=1", stall); end
    chk_reg2 = 5'd8;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall_other got=%0h exp=0", stall); end
    chk_reg1 = 5'd5;
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h5555_5555;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_during_xfer got=%0h exp=1", stall); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall_after_retire got=%0h exp=0", stall); end
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL sb_count_after_retire got=%0d exp=0", busy_count); end
    chk_reg1 = 5'd0; chk_reg2 = 5'd0;
  endtask

  task automatic test_reg0();
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 5'd0;
    @(posedge clk); #1;
    claim_valid = 1'b0;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0h exp=0", stall); end
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL r0_busy_count got=%0d exp=0", busy_count); end
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL r0_a_ready got=%0h exp=1", a_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL r0_regWrite got=%0h exp=0", regWrite); end
    checks++; if (busy_count !== 6'd0 || stall !== 1'b0) begin failures++; $display("FAIL r0_after got_count=%0d stall=%0b exp=0/0", busy_count, stall); end
  endtask

  task automatic test_same_edge();
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 5'd9;
    @(negedge clk);
    // Claim reg 9 again on the same edge where A retires reg 9.
    a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h9;
    chk_reg1 = 5'd9;
    @(posedge clk); #1;
    claim_valid = 1'b0; a_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL same_busy9 got=%0h exp=1", stall); end
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", busy_count); end
    checks++; if (claim_err !== 1'b0) begin failures++; $display("FAIL same_claim_err got=%0h exp=0", claim_err); end
    checks++; if (regWrite !== 1'b1 || write_reg !== 5'd9) begin failures++; $display("FAIL same_write got_we=%0b reg=%0d exp=1/9", regWrite, write_reg); end
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd9;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (busy_count !== 6'd0 || stall !== 1'b0) begin failures++; $display("FAIL same_final got_count=%0d stall=%0b exp=0/0", busy_count, stall); end
    chk_reg1 = 5'd0;
  endtask

  task automatic test_retire_nonbusy();
    @(negedge clk);
    b_valid = 1'b1; b_reg = 5'd10; b_data = 32'hA; chk_reg1 = 5'd10;
    @(posedge clk); #1;
    b_valid = 1'b0;
    checks++; if (busy_count !== 6'd0 || stall !== 1'b0 || claim_err !== 1'b0) begin
      failures++; $display("FAIL nonbusy_retire got_count=%0d stall=%0b err=%0b exp=0/0/0", busy_count, stall, claim_err);
    end
    chk_reg1 = 5'd0;
  endtask

  task automatic test_claim_err();
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 5'd6;
    @(posedge clk); #1;
    checks++; if (claim_err !== 1'b0) begin failures++; $display("FAIL err_first_claim got=%0h exp=0", claim_err); end
    @(posedge clk); #1;
    claim_valid = 1'b0;
    checks++; if (claim_err !== 1'b1) begin failures++; $display("FAIL err_second_claim got=%0h exp=1", claim_err); end
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL err_busy_count got=%0d exp=1", busy_count); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (claim_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h exp=1", claim_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h1234_5678;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (regWrite !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0h exp=1", regWrite); end
    reset = 1'b1;
    #1;
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL mid_regWrite got=%0h exp=0", regWrite); end
    checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin failures++; $display("FAIL mid_write_port got_reg=%0d data=%0h exp=0/0", write_reg, write_data); end
    checks++; if (busy_count !== 6'd0 || claim_err !== 1'b0) begin failures++; $display("FAIL mid_scoreboard got_count=%0d err=%0b exp=0/0", busy_count, claim_err); end
    chk_reg1 = 5'd6;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mid_stall got=%0h exp=0", stall); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_byte_b();
    test_scoreboard();
    test_reg0();
    test_same_edge();
    test_retire_nonbusy();
    test_claim_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
